// File: rtl/mips_multicycle_ctrl.sv
// Multicycle main control FSM for the MIPS CPU.
// Moore outputs decoded from the state register; pc_en in BEQ follows zero.
// Counts instructions that complete back into FETCH.
module mips_multicycle_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  opcode,
    input  logic [5:0]  funct,
    input  logic        zero,
    output logic        iord,
    output logic        mem_read,
    output logic        mem_write,
    output logic        ir_write,
    output logic        reg_dst,
    output logic        mem_to_reg,
    output logic        reg_write,
    output logic        alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [1:0]  alu_sel,
    output logic [1:0]  pc_src,
    output logic        pc_en,
    output logic        illegal,
    output logic [3:0]  state,
    output logic [31:0] retired
);

    typedef enum logic [3:0] {
        StFetch   = 4'd0,
        StDecode  = 4'd1,
        StMemAdr  = 4'd2,
        StMemRd   = 4'd3,
        StMemWb   = 4'd4,
        StMemWr   = 4'd5,
        StRtypeEx = 4'd6,
        StRtypeWb = 4'd7,
        StBeq     = 4'd8,
        StAddiEx  = 4'd9,
        StAddiWb  = 4'd10,
        StJump    = 4'd11
    } state_t;

    localparam logic [5:0] OpRtype = 6'h00;
    localparam logic [5:0] OpLw    = 6'h23;
    localparam logic [5:0] OpSw    = 6'h2b;
    localparam logic [5:0] OpBeq   = 6'h04;
    localparam logic [5:0] OpAddi  = 6'h08;
    localparam logic [5:0] OpJ     = 6'h02;

    state_t      state_q;
    logic [31:0] retired_q;
    logic        funct_ok;
    logic        instr_ok;

    // Instruction legality decode; opcode/funct are stable from DECODE onward
    always_comb begin
        funct_ok = (funct == 6'h20) || (funct == 6'h22) ||
                   (funct == 6'h24) || (funct == 6'h25);
        instr_ok = ((opcode == OpRtype) && funct_ok) || (opcode == OpLw) ||
                   (opcode == OpSw) || (opcode == OpBeq) || (opcode == OpAddi) ||
                   (opcode == OpJ);
    end

    // State sequencing and retired-instruction counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StFetch;
            retired_q <= 32'd0;
        end else begin
            case (state_q)
                StFetch: state_q <= StDecode;
                StDecode: begin
                    if (!instr_ok) begin
                        state_q <= StFetch;
                    end else begin
                        case (opcode)
                            OpLw, OpSw: state_q <= StMemAdr;
                            OpRtype:    state_q <= StRtypeEx;
                            OpBeq:      state_q <= StBeq;
                            OpAddi:     state_q <= StAddiEx;
                            OpJ:        state_q <= StJump;
                            default:    state_q <= StFetch;
                        endcase
                    end
                end
                StMemAdr:  state_q <= (opcode == OpSw) ? StMemWr : StMemRd;
                StMemRd:   state_q <= StMemWb;
                StRtypeEx: state_q <= StRtypeWb;
                StAddiEx:  state_q <= StAddiWb;
                StMemWb, StMemWr, StRtypeWb, StBeq, StAddiWb, StJump: begin
                    state_q   <= StFetch;
                    retired_q <= retired_q + 32'd1;
                end
                // Unused encodings recover to FETCH without retiring anything
                default: state_q <= StFetch;
            endcase
        end
    end

    // Output decode from the registered state; reset holds every strobe low
    always_comb begin
        iord       = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        alu_sel    = 2'b00;
        pc_src     = 2'b00;
        pc_en      = 1'b0;
        illegal    = 1'b0;
        if (!rst) begin
            case (state_q)
                StFetch: begin
                    mem_read  = 1'b1;
                    ir_write  = 1'b1;
                    alu_src_b = 2'b01;
                    pc_en     = 1'b1;
                end
                StDecode: begin
                    alu_src_b = 2'b11;
                    illegal   = !instr_ok;
                end
                StMemAdr: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                end
                StMemRd: begin
                    iord     = 1'b1;
                    mem_read = 1'b1;
                end
                StMemWb: begin
                    mem_to_reg = 1'b1;
                    reg_write  = 1'b1;
                end
                StMemWr: begin
                    iord      = 1'b1;
                    mem_write = 1'b1;
                end
                StRtypeEx: begin
                    alu_src_a = 1'b1;
                    case (funct)
                        6'h22:   alu_sel = 2'b01;
                        6'h24:   alu_sel = 2'b10;
                        6'h25:   alu_sel = 2'b11;
                        default: alu_sel = 2'b00;
                    endcase
                end
                StRtypeWb: begin
                    reg_dst   = 1'b1;
                    reg_write = 1'b1;
                end
                StBeq: begin
                    alu_src_a = 1'b1;
                    alu_sel   = 2'b01;
                    pc_src    = 2'b01;
                    pc_en     = zero;
                end
                StAddiEx: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                end
                StAddiWb: reg_write = 1'b1;
                StJump: begin
                    pc_src = 2'b10;
                    pc_en  = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign state   = state_q;
    assign retired = retired_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Scoreboard bench for mips_multicycle_ctrl: the stimulus process pushes the
// per-cycle expected output picture of each instruction; a monitor pops and
// compares once per cycle.
module tb_mips_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [5:0]  opcode = 6'h00;
    logic [5:0]  funct = 6'h00;
    logic        zero = 1'b0;
    logic        iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg;
    logic        reg_write, alu_src_a, pc_en, illegal;
    logic [1:0]  alu_src_b, alu_sel, pc_src;
    logic [3:0]  state;
    logic [31:0] retired;

    typedef struct packed {
        logic        iord;
        logic        mem_read;
        logic        mem_write;
        logic        ir_write;
        logic        reg_dst;
        logic        mem_to_reg;
        logic        reg_write;
        logic        alu_src_a;
        logic [1:0]  alu_src_b;
        logic [1:0]  alu_sel;
        logic [1:0]  pc_src;
        logic        pc_en;
        logic        illegal;
        logic [3:0]  state;
        logic [31:0] retired;
    } obs_t;

    obs_t        act;
    obs_t        exp_q[$];
    string       tag_q[$];
    int          checks = 0;
    int          failures = 0;
    logic [31:0] model_ret = 32'd0;

    mips_multicycle_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .opcode     (opcode),
        .funct      (funct),
        .zero       (zero),
        .iord       (iord),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .ir_write   (ir_write),
        .reg_dst    (reg_dst),
        .mem_to_reg (mem_to_reg),
        .reg_write  (reg_write),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .alu_sel    (alu_sel),
        .pc_src     (pc_src),
        .pc_en      (pc_en),
        .illegal    (illegal),
        .state      (state),
        .retired    (retired)
    );

    always #5 clk = ~clk;

    assign act = {iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
                  alu_src_a, alu_src_b, alu_sel, pc_src, pc_en, illegal, state, retired};

    function automatic obs_t blank(input logic [3:0] st);
        obs_t e;
        e = '0;
        e.state = st;
        e.retired = model_ret;
        return e;
    endfunction

    task automatic push(input obs_t e, input string tag);
        exp_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    // Reference: what each cycle of an instruction must look like
    task automatic expect_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                                input string tag, output int n);
        obs_t e;
        logic legal;
        legal = (op == 6'h00) ? (fn == 6'h20 || fn == 6'h22 || fn == 6'h24 || fn == 6'h25)
                              : (op == 6'h23 || op == 6'h2b || op == 6'h04 ||
                                 op == 6'h08 || op == 6'h02);
        e = blank(4'd0);
        e.mem_read = 1'b1; e.ir_write = 1'b1; e.alu_src_b = 2'b01; e.pc_en = 1'b1;
        push(e, {tag, ".fetch"});
        e = blank(4'd1);
        e.alu_src_b = 2'b11; e.illegal = !legal;
        push(e, {tag, ".decode"});
        n = 2;
        if (legal) begin
            if (op == 6'h23 || op == 6'h2b) begin
                e = blank(4'd2); e.alu_src_a = 1'b1; e.alu_src_b = 2'b10;
                push(e, {tag, ".memadr"});
                if (op == 6'h23) begin
                    e = blank(4'd3); e.iord = 1'b1; e.mem_read = 1'b1;
                    push(e, {tag, ".memrd"});
                    e = blank(4'd4); e.mem_to_reg = 1'b1; e.reg_write = 1'b1;
                    push(e, {tag, ".memwb"});
                    n = 5;
                end else begin
                    e = blank(4'd5); e.iord = 1'b1; e.mem_write = 1'b1;
                    push(e, {tag, ".memwr"});
                    n = 4;
                end
            end else if (op == 6'h00) begin
                e = blank(4'd6); e.alu_src_a = 1'b1;
                case (fn)
                    6'h20:   e.alu_sel = 2'd0;
                    6'h22:   e.alu_sel = 2'd1;
                    6'h24:   e.alu_sel = 2'd2;
                    default: e.alu_sel = 2'd3;
                endcase
                push(e, {tag, ".rex"});
                e = blank(4'd7); e.reg_dst = 1'b1; e.reg_write = 1'b1;
                push(e, {tag, ".rwb"});
                n = 4;
            end else if (op == 6'h04) begin
                e = blank(4'd8); e.alu_src_a = 1'b1; e.alu_sel = 2'b01;
                e.pc_src = 2'b01; e.pc_en = z;
                push(e, {tag, ".beq"});
                n = 3;
            end else if (op == 6'h08) begin
                e = blank(4'd9); e.alu_src_a = 1'b1; e.alu_src_b = 2'b10;
                push(e, {tag, ".addiex"});
                e = blank(4'd10); e.reg_write = 1'b1;
                push(e, {tag, ".addiwb"});
                n = 4;
            end else begin
                e = blank(4'd11); e.pc_src = 2'b10; e.pc_en = 1'b1;
                push(e, {tag, ".jump"});
                n = 3;
            end
            model_ret = model_ret + 32'd1;
        end
    endtask

    // Called at a falling edge inside a FETCH cycle; returns at the next one
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                             input string tag);
        int n;
        expect_instr(op, fn, z, tag, n);
        opcode = op;
        funct  = fn;
        zero   = z;
        repeat (n) @(negedge clk);
    endtask

    task automatic hold_reset(input int cycles);
        obs_t e;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            e = blank(4'd0);
            push(e, "reset");
        end
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
    endtask

    // Monitor: one comparison per cycle while expectations are queued
    initial begin
        obs_t  e;
        string t;
        forever begin
            @(negedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                t = tag_q.pop_front();
                checks++;
                if (act !== e) begin
                    failures++;
                    $display("FAIL %s act=%h exp=%h (state act=%0d exp=%0d retired act=%h exp=%h)",
                             t, act, e, act.state, e.state, act.retired, e.retired);
                end
            end
        end
    end

    initial begin
        int          n;
        int          r;
        logic [5:0]  op;
        logic [5:0]  fn;
        logic [5:0]  fns [4];
        fns[0] = 6'h20; fns[1] = 6'h22; fns[2] = 6'h24; fns[3] = 6'h25;

        model_ret = 32'd0;
        hold_reset(1);

        // Reset while in RTYPE_EX: expect FETCH, DECODE, RTYPE_EX then abort
        expect_instr(6'h00, 6'h22, 1'b0, "rst_mid", n);
        void'(exp_q.pop_back());
        void'(tag_q.pop_back());
        opcode = 6'h00; funct = 6'h22;
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        model_ret = 32'd0;
        hold_reset(2);

        run_instr(6'h23, 6'h00, 1'b0, "lw");
        run_instr(6'h2b, 6'h00, 1'b0, "sw");
        for (int i = 0; i < 4; i++) run_instr(6'h00, fns[i], 1'b0, "rtype");
        run_instr(6'h04, 6'h00, 1'b1, "beq_taken");
        run_instr(6'h04, 6'h00, 1'b0, "beq_not");
        run_instr(6'h08, 6'h11, 1'b0, "addi");
        run_instr(6'h3f, 6'h00, 1'b0, "illegal_op");
        run_instr(6'h00, 6'h2a, 1'b0, "illegal_funct");

        // Preload the counter just below wrap, then retire a jump
        force dut.retired_q = 32'hffff_ffff;
        model_ret = 32'hffff_ffff;
        expect_instr(6'h02, 6'h00, 1'b0, "jump_wrap", n);
        opcode = 6'h02; funct = 6'h00; zero = 1'b0;
        #1 release dut.retired_q;
        repeat (n) @(negedge clk);
        run_instr(6'h2b, 6'h00, 1'b1, "sw_after_wrap");

        // Randomized instruction mix
        for (int i = 0; i < 150; i++) begin
            r  = $urandom_range(0, 9);
            fn = 6'($urandom_range(0, 63));
            case (r)
                0:       op = 6'h23;
                1:       op = 6'h2b;
                2, 3: begin
                    op = 6'h00;
                    fn = fns[$urandom_range(0, 3)];
                end
                4, 9:    op = 6'h04;
                5:       op = 6'h08;
                6:       op = 6'h02;
                7:       op = 6'($urandom_range(0, 63));
                default: op = 6'h00;
            endcase
            run_instr(op, fn, 1'($urandom_range(0, 1)), "rand");
        end

        repeat (2) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain act=%0d exp=0 entries left", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
